// File: rtl/nios_sysid_checker.sv
// nios_sysid_checker
// Reads the two words of a Nios II sysid slave (ID at word 0, timestamp at
// word 1), compares them against the expected build values and reports the
// result. A mismatch triggers up to MAX_RETRY complete re-reads before the
// check is declared finished. All outputs are registered.
module nios_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned MAX_RETRY   = 2,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [2:0]  retry_cnt
);

    localparam logic [3:0] LAT  = 4'(READ_LAT);
    localparam logic [2:0] MAXR = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        COMPARE,
        DONE
    } state_t;

    state_t      state_q;
    logic [3:0]  wait_q;
    logic        auto_pend_q;
    logic        addr_q;
    logic        read_q;
    logic        busy_q;
    logic        done_q;
    logic        match_q;
    logic        id_ok_q;
    logic        ts_ok_q;
    logic [31:0] cap_id_q;
    logic [31:0] cap_ts_q;
    logic [2:0]  retry_q;

    logic        id_ok_d;
    logic        ts_ok_d;

    // Word comparisons against the expected build values.
    always_comb begin
        id_ok_d = (cap_id_q == EXPECTED_ID);
        ts_ok_d = (cap_ts_q == EXPECTED_TS);
    end

    // Check sequencer; every output is produced as a register alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            auto_pend_q <= AUTO_START;
            addr_q      <= 1'b0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
            cap_id_q    <= 32'd0;
            cap_ts_q    <= 32'd0;
            retry_q     <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The auto-start request is consumed once, so it fires
                    // only on the first IDLE visit after reset release.
                    if (start || auto_pend_q) begin
                        state_q     <= RD_ID;
                        auto_pend_q <= 1'b0;
                        retry_q     <= 3'd0;
                        match_q     <= 1'b0;
                        wait_q      <= 4'd0;
                        read_q      <= 1'b1;
                        addr_q      <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                RD_ID: begin
                    if (wait_q == LAT) begin
                        cap_id_q <= sysid_readdata;
                        wait_q   <= 4'd0;
                        addr_q   <= 1'b1;
                        state_q  <= RD_TS;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                RD_TS: begin
                    if (wait_q == LAT) begin
                        cap_ts_q <= sysid_readdata;
                        wait_q   <= 4'd0;
                        addr_q   <= 1'b0;
                        read_q   <= 1'b0;
                        state_q  <= COMPARE;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                COMPARE: begin
                    id_ok_q <= id_ok_d;
                    ts_ok_q <= ts_ok_d;
                    // match is loaded here so it is valid during the done pulse.
                    if ((id_ok_d && ts_ok_d) || (retry_q == MAXR)) begin
                        match_q <= id_ok_d & ts_ok_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        retry_q <= retry_q + 3'd1;
                        read_q  <= 1'b1;
                        addr_q  <= 1'b0;
                        state_q <= RD_ID;
                    end
                end
                DONE: begin
                    // start seen here is dropped; only IDLE accepts it.
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    read_q  <= 1'b0;
                    addr_q  <= 1'b0;
                    wait_q  <= 4'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sysid_address = addr_q;
    assign sysid_read    = read_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign match         = match_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign captured_id   = cap_id_q;
    assign captured_ts   = cap_ts_q;
    assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Bench for nios_sysid_checker: three instances (READ_LAT 1 with auto-start,
// READ_LAT 0 and READ_LAT 15 without), a shared sysid slave model that
// returns a programmable word pair per read pass, directed table vectors,
// randomized checks against a pass-level reference model, and hand-written
// sequences for reset abort, busy-start and latency sweep.
module tb_nios_sysid_checker;

    localparam logic [31:0] TS_M   = 32'h5E42_7A44;
    localparam logic [31:0] ID_X   = 32'h1234_5678;
    localparam logic [31:0] TS_X   = 32'h9ABC_DEF0;
    localparam logic [31:0] BAD_ID = 32'hDEAD_0001;
    localparam logic [31:0] BAD_TS = 32'h0000_0001;
    localparam int          MR     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  sel;
    logic        slave_clr;

    logic [2:0]  w_start, w_addr, w_rd, w_busy, w_done, w_match, w_idok, w_tsok;
    logic [31:0] w_rdata [3];
    logic [31:0] w_cid   [3];
    logic [31:0] w_cts   [3];
    logic [2:0]  w_rc    [3];

    logic [31:0] id_resp [8];
    logic [31:0] ts_resp [8];
    logic [2:0]  pidx;
    logic        ts_seen;

    logic        obs_addr, obs_rd, obs_busy, obs_done, obs_match, obs_idok, obs_tsok;
    logic [31:0] obs_cid, obs_cts;
    logic [2:0]  obs_rc;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    nios_sysid_checker #(.EXPECTED_ID(32'h0), .EXPECTED_TS(TS_M), .READ_LAT(1),
                         .MAX_RETRY(MR), .AUTO_START(1'b1)) u_m (
        .clock(clk), .reset(reset), .start(w_start[0]),
        .sysid_address(w_addr[0]), .sysid_read(w_rd[0]), .sysid_readdata(w_rdata[0]),
        .busy(w_busy[0]), .done(w_done[0]), .match(w_match[0]),
        .id_ok(w_idok[0]), .ts_ok(w_tsok[0]),
        .captured_id(w_cid[0]), .captured_ts(w_cts[0]), .retry_cnt(w_rc[0]));

    nios_sysid_checker #(.EXPECTED_ID(ID_X), .EXPECTED_TS(TS_X), .READ_LAT(0),
                         .MAX_RETRY(MR), .AUTO_START(1'b0)) u_l0 (
        .clock(clk), .reset(reset), .start(w_start[1]),
        .sysid_address(w_addr[1]), .sysid_read(w_rd[1]), .sysid_readdata(w_rdata[1]),
        .busy(w_busy[1]), .done(w_done[1]), .match(w_match[1]),
        .id_ok(w_idok[1]), .ts_ok(w_tsok[1]),
        .captured_id(w_cid[1]), .captured_ts(w_cts[1]), .retry_cnt(w_rc[1]));

    nios_sysid_checker #(.EXPECTED_ID(ID_X), .EXPECTED_TS(TS_X), .READ_LAT(15),
                         .MAX_RETRY(MR), .AUTO_START(1'b0)) u_l15 (
        .clock(clk), .reset(reset), .start(w_start[2]),
        .sysid_address(w_addr[2]), .sysid_read(w_rd[2]), .sysid_readdata(w_rdata[2]),
        .busy(w_busy[2]), .done(w_done[2]), .match(w_match[2]),
        .id_ok(w_idok[2]), .ts_ok(w_tsok[2]),
        .captured_id(w_cid[2]), .captured_ts(w_cts[2]), .retry_cnt(w_rc[2]));

    assign w_start[0] = start && (sel == 2'd0);
    assign w_start[1] = start && (sel == 2'd1);
    assign w_start[2] = start && (sel == 2'd2);

    assign obs_addr  = w_addr[sel];
    assign obs_rd    = w_rd[sel];
    assign obs_busy  = w_busy[sel];
    assign obs_done  = w_done[sel];
    assign obs_match = w_match[sel];
    assign obs_idok  = w_idok[sel];
    assign obs_tsok  = w_tsok[sel];
    assign obs_cid   = w_cid[sel];
    assign obs_cts   = w_cts[sel];
    assign obs_rc    = w_rc[sel];

    // Slave: word selected by address, value chosen by the current read pass.
    always_comb begin
        for (int k = 0; k < 3; k++)
            w_rdata[k] = w_addr[k] ? ts_resp[pidx] : id_resp[pidx];
    end

    // Read-pass counter: a pass ends when the timestamp read strobe goes away.
    always @(posedge clk) begin
        if (slave_clr) begin
            pidx    <= 3'd0;
            ts_seen <= 1'b0;
        end else if (obs_rd && obs_addr) begin
            ts_seen <= 1'b1;
        end else if (ts_seen) begin
            pidx    <= pidx + 3'd1;
            ts_seen <= 1'b0;
        end
    end

    function automatic int lat_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 0 : 15;
    endfunction

    function automatic logic [31:0] eid_of(input logic [1:0] s);
        return (s == 2'd0) ? 32'h0 : ID_X;
    endfunction

    function automatic logic [31:0] ets_of(input logic [1:0] s);
        return (s == 2'd0) ? TS_M : TS_X;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic fill_good(input logic [1:0] s);
        for (int r = 0; r < 8; r++) begin
            id_resp[r] = eid_of(s);
            ts_resp[r] = ets_of(s);
        end
    endtask

    // Launch one check (by start pulse or by reset release) and verify it.
    task automatic run_and_check(input string nm, input logic [1:0] s, input bit via_reset,
                                 input int exp_cyc, input bit em, input bit ei, input bit et,
                                 input int er, input logic [31:0] ecid, input logic [31:0] ects);
        int L, per, budget, cyc, ph, bad_c;
        bit pat_ok, seen;
        L = lat_of(s); per = 2 * L + 3; budget = (MR + 1) * per + 4;
        pat_ok = 1'b1; seen = 1'b0; bad_c = 0;
        sel = s;
        @(negedge clk);
        slave_clr = 1'b1;
        if (via_reset) reset = 1'b0;
        else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; slave_clr = 1'b0; cyc = 1;
        chk({nm, " match cleared on accept"}, 32'(obs_match), 32'd0);
        chk({nm, " busy after accept"}, 32'(obs_busy), 32'd1);
        while (cyc <= budget) begin
            if (obs_done) begin
                seen = 1'b1;
                break;
            end
            ph = (cyc - 1) % per;
            if (obs_rd !== (ph < 2 * L + 2) || obs_addr !== (ph >= L + 1 && ph < 2 * L + 2)
                || obs_busy !== 1'b1) begin
                if (pat_ok) bad_c = cyc;
                pat_ok = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, " done seen"}, 32'(seen), 32'd1);
        chk({nm, " read/address pattern (first bad cycle in got)"}, pat_ok ? 32'd0 : 32'(bad_c), 32'd0);
        chk({nm, " done cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({nm, " match"}, 32'(obs_match), 32'(em));
        chk({nm, " id_ok"}, 32'(obs_idok), 32'(ei));
        chk({nm, " ts_ok"}, 32'(obs_tsok), 32'(et));
        chk({nm, " retry_cnt"}, 32'(obs_rc), 32'(er));
        chk({nm, " captured_id"}, obs_cid, ecid);
        chk({nm, " captured_ts"}, obs_cts, ects);
        chk({nm, " read idle at done"}, {30'd0, obs_rd, obs_addr}, 32'd0);
        @(posedge clk); #1;
        chk({nm, " done one cycle"}, {30'd0, obs_done, obs_busy}, 32'd0);
        @(posedge clk); #1;
        chk({nm, " match held"}, 32'(obs_match), 32'(em));
        chk({nm, " captured_ts held"}, obs_cts, ects);
    endtask

    typedef struct {
        logic [2:0]  id_bad;
        logic [2:0]  ts_bad;
        int          dcyc;
        bit          m, iok, tok;
        int          rc;
        logic [31:0] cid, cts;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [31:0] eid, ets;
        int r, L, n;
        bit flag;
        logic [1:0] s;

        tbl[0] = '{3'b000, 3'b000,  6, 1'b1, 1'b1, 1'b1, 0, 32'h0,  TS_M};
        tbl[1] = '{3'b000, 3'b111, 16, 1'b0, 1'b1, 1'b0, 2, 32'h0,  BAD_TS};
        tbl[2] = '{3'b001, 3'b000, 11, 1'b1, 1'b1, 1'b1, 1, 32'h0,  TS_M};
        tbl[3] = '{3'b111, 3'b000, 16, 1'b0, 1'b0, 1'b1, 2, BAD_ID, TS_M};
        tbl[4] = '{3'b011, 3'b011, 16, 1'b1, 1'b1, 1'b1, 2, 32'h0,  TS_M};
        tbl[5] = '{3'b001, 3'b010, 16, 1'b1, 1'b1, 1'b1, 2, 32'h0,  TS_M};
        tbl[6] = '{3'b111, 3'b111, 16, 1'b0, 1'b0, 1'b0, 2, BAD_ID, BAD_TS};

        reset = 1'b1; start = 1'b0; sel = 2'd0; slave_clr = 1'b0;
        fill_good(2'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy/done/match/id_ok/ts_ok/read/addr",
            {25'd0, obs_busy, obs_done, obs_match, obs_idok, obs_tsok, obs_rd, obs_addr}, 32'd0);
        chk("reset captured_id", obs_cid, 32'd0);
        chk("reset captured_ts", obs_cts, 32'd0);
        chk("reset retry_cnt", 32'(obs_rc), 32'd0);

        // Auto-start on the first edge after reset release.
        run_and_check("auto_start", 2'd0, 1'b1, 6, 1'b1, 1'b1, 1'b1, 0, 32'h0, TS_M);
        chk("no auto-start when disabled", {30'd0, w_busy[1], w_busy[2]}, 32'd0);

        // Directed table on the READ_LAT=1 instance.
        for (int i = 0; i < 7; i++) begin
            fill_good(2'd0);
            for (int k = 0; k < 3; k++) begin
                if (tbl[i].id_bad[k]) id_resp[k] = BAD_ID;
                if (tbl[i].ts_bad[k]) ts_resp[k] = BAD_TS;
            end
            run_and_check($sformatf("vec%0d", i), 2'd0, 1'b0, tbl[i].dcyc, tbl[i].m,
                          tbl[i].iok, tbl[i].tok, tbl[i].rc, tbl[i].cid, tbl[i].cts);
        end

        // Randomized checks: the model finds the first fully matching pass.
        for (int i = 0; i < 12; i++) begin
            s = 2'($urandom_range(0, 2));
            eid = eid_of(s); ets = ets_of(s); L = lat_of(s);
            for (int k = 0; k < 8; k++) begin
                id_resp[k] = ($urandom_range(0, 2) != 0) ? eid : $urandom;
                ts_resp[k] = ($urandom_range(0, 2) != 0) ? ets : $urandom;
            end
            r = 0;
            while (r < MR && !(id_resp[r] == eid && ts_resp[r] == ets)) r++;
            run_and_check($sformatf("rand%0d", i), s, 1'b0, (r + 1) * (2 * L + 3) + 1,
                          (id_resp[r] == eid) && (ts_resp[r] == ets),
                          id_resp[r] == eid, ts_resp[r] == ets, r, id_resp[r], ts_resp[r]);
        end

        // Latency sweep.
        fill_good(2'd1);
        run_and_check("lat0", 2'd1, 1'b0, 4, 1'b1, 1'b1, 1'b1, 0, ID_X, TS_X);
        fill_good(2'd2);
        run_and_check("lat15", 2'd2, 1'b0, 34, 1'b1, 1'b1, 1'b1, 0, ID_X, TS_X);

        // start held for 20 cycles: one check per IDLE visit, period 5.
        sel = 2'd1;
        fill_good(2'd1);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            @(posedge clk); #1;
            if (c == 20) start = 1'b0;
            chk($sformatf("busystart done c%0d", c), 32'(obs_done), 32'(c < 20 && c % 5 == 4));
            chk($sformatf("busystart busy c%0d", c), 32'(obs_busy), 32'(c < 20 && c % 5 != 0));
        end

        // Reset during RD_TS aborts the check; auto-start follows release.
        fill_good(2'd0);
        run_and_check("pre_rst", 2'd0, 1'b0, 6, 1'b1, 1'b1, 1'b1, 0, 32'h0, TS_M);
        for (int k = 0; k < 8; k++) id_resp[k] = BAD_ID;
        @(negedge clk);
        start = 1'b1; slave_clr = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; slave_clr = 1'b0;
        n = 0;
        while (!obs_addr && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst reached RD_TS", 32'(obs_addr), 32'd1);
        chk("rst captured_id before reset", obs_cid, BAD_ID);
        #2 reset = 1'b1;
        #1;
        chk("rst busy/done/match/id_ok/ts_ok/read/addr",
            {25'd0, obs_busy, obs_done, obs_match, obs_idok, obs_tsok, obs_rd, obs_addr}, 32'd0);
        chk("rst captured_id", obs_cid, 32'd0);
        chk("rst captured_ts", obs_cts, 32'd0);
        chk("rst retry_cnt", 32'(obs_rc), 32'd0);
        flag = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (obs_done || obs_busy) flag = 1'b1;
        end
        chk("rst no done/busy while held", 32'(flag), 32'd0);
        fill_good(2'd0);
        run_and_check("after_rst", 2'd0, 1'b1, 6, 1'b1, 1'b1, 1'b1, 0, 32'h0, TS_M);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
